filter_rd_seq: RTL and testbench
================================

// Module: filter_rd_seq
// PURPOSE
//  Read sequencer for the filter SRAM (combinational read, addressed by chunk index and bus-beat index).
//  On start it walks CHUNK_NUM consecutive chunks from CHUNK_BASE, issuing every beat of each chunk in order.
//  Captures each sparsemap/nonzero-data beat into a one-entry output register with valid/ready toward the PE array.
//  Reports busy, per-chunk last, stream last and done.
// PARAMETERS
//  BUS_SIZE        32  sparsemap bits (and data bytes) per beat
//  WR_DAT_CYC_NUM   4  beats per chunk (CHUNK_SIZE/BUS_SIZE); power of two, >=2
//  SRAM_FILTER_NUM  8  chunks in filter SRAM; power of two, >=2
//  Derived: DW=$clog2(WR_DAT_CYC_NUM), CW=$clog2(SRAM_FILTER_NUM)
// PORTS
//  clk_i              in   1           clock, all logic on rising edge
//  rst_i              in   1           synchronous, active-high reset
//  start_i            in   1           request stream; accepted only in IDLE
//  abort_i            in   1           cancel stream; IDLE next cycle
//  chunk_base_i       in   CW          first chunk index, sampled at accepted start
//  chunk_num_i        in   CW+1        chunks to stream, 0..SRAM_FILTER_NUM, sampled at accepted start
//  rd_dat_count_o     out  DW          beat address to filter SRAM
//  rd_chunk_count_o   out  CW          chunk address to filter SRAM
//  mem_sparsemap_i    in   BUS_SIZE    SRAM sparsemap read data (same cycle as address)
//  mem_data_i         in   BUS_SIZE*8  SRAM nonzero data read data (same cycle as address)
//  out_valid_o        out  1           output beat valid
//  out_ready_i        in   1           consumer accepts beat when valid&ready
//  out_sparsemap_o    out  BUS_SIZE    registered sparsemap beat
//  out_data_o         out  BUS_SIZE*8  registered data beat
//  out_chunk_last_o   out  1           beat is last beat of its chunk
//  out_last_o         out  1           beat is last beat of whole stream
//  busy_o             out  1           state != IDLE
//  done_o             out  1           one-cycle pulse: final beat consumed
// BEHAVIOUR
//  Reset: state=IDLE; addresses, out_* data, out_valid_o, out_*last_o, busy_o, done_o all 0.
//  FSM IDLE -> RUN  : start_i & !abort_i & chunk_num_i!=0; load chunk=base, beat=0, remaining=chunk_num_i.
//      IDLE -> IDLE : start_i & chunk_num_i==0 -> done_o pulses next cycle, no beats issued.
//      RUN  -> DRAIN: issue of final beat (last beat of last chunk).
//      DRAIN-> IDLE : final beat accepted (out_valid_o & out_ready_i); done_o=1 that next cycle.
//      any  -> IDLE : abort_i (wins over start_i and issue); out_valid_o cleared, no done_o.
//  start_i outside IDLE is ignored (no queuing).
//  Issue = (state==RUN) & (!out_valid_o | out_ready_i). On issue: out regs <= mem_*_i (current address),
//    out_valid_o<=1, chunk/stream last flags computed from current counters; beat increments.
//  beat wraps WR_DAT_CYC_NUM-1 -> 0 with chunk+1; chunk wraps SRAM_FILTER_NUM-1 -> 0 (modulo).
//  Acceptance without issue clears out_valid_o; out_* data hold when not valid (no X pass-through).
//  Throughput 1 beat/cycle with out_ready_i=1; latency accepted start (cycle 0) -> first out_valid_o at cycle 2.
//  Addresses hold when not issuing; under backpressure the beat held in out regs is not reissued or lost.
//  Total beats per stream = chunk_num*WR_DAT_CYC_NUM; chunk_num=SRAM_FILTER_NUM reads all chunks once.
//  rst_i mid-stream: same as reset, discards held beat, no done_o.
// TESTING
//  base=0,num=2,ready=1: 8 beats, addr (c,b)=(0,0)..(1,3); chunk_last on beats 3,7; out_last beat 7; done_o cycle 10.
//  base=7,num=2 (SRAM_FILTER_NUM=8): chunks 7 then 0 -> wrap checked; data matches SRAM model per beat.
//  num=1, ready toggles 1010..: each beat held stable while ready=0, no duplicate/dropped beat, done after 4th accept.
//  abort_i at 3rd beat of num=3: busy_o=0 and out_valid_o=0 next cycle, done_o never pulses; new start works.
//  start with num=0 -> done_o single pulse next cycle, out_valid_o stays 0; start while busy ignored.
//  rst_i asserted mid-stream under ready=0 -> all outputs to reset values next cycle.

Source files
------------

// File: rtl/filter_rd_seq.sv
// filter_rd_seq: streams CHUNK_NUM consecutive filter chunks out of the filter SRAM, beat by beat.
// Ports: clk_i/rst_i (sync, active-high); start_i/abort_i with chunk_base_i/chunk_num_i control a stream;
// rd_chunk_count_o/rd_dat_count_o address the SRAM, whose combinational read returns mem_sparsemap_i/mem_data_i;
// out_* is a one-entry valid/ready register toward the PE array; busy_o, done_o report stream status.
module filter_rd_seq #(
    parameter int BUS_SIZE        = 32,
    parameter int WR_DAT_CYC_NUM  = 4,
    parameter int SRAM_FILTER_NUM = 8,
    localparam int DW = $clog2(WR_DAT_CYC_NUM),
    localparam int CW = $clog2(SRAM_FILTER_NUM)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic [CW-1:0]         chunk_base_i,
    input  logic [CW:0]           chunk_num_i,
    output logic [DW-1:0]         rd_dat_count_o,
    output logic [CW-1:0]         rd_chunk_count_o,
    input  logic [BUS_SIZE-1:0]   mem_sparsemap_i,
    input  logic [BUS_SIZE*8-1:0] mem_data_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [BUS_SIZE-1:0]   out_sparsemap_o,
    output logic [BUS_SIZE*8-1:0] out_data_o,
    output logic                  out_chunk_last_o,
    output logic                  out_last_o,
    output logic                  busy_o,
    output logic                  done_o
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;
    state_e                state_q, state_d;
    logic [DW-1:0]         beat_q, beat_d;
    logic [CW-1:0]         chunk_q, chunk_d;
    logic [CW:0]           rem_q, rem_d;
    logic                  valid_q, valid_d, cl_q, cl_d, last_q, last_d, done_q, done_d;
    logic [BUS_SIZE-1:0]   sm_q, sm_d;
    logic [BUS_SIZE*8-1:0] data_q, data_d;
    logic                  issue, accept, beat_last;
    assign issue     = (state_q == RUN) && (!valid_q || out_ready_i);
    assign accept    = valid_q && out_ready_i;
    assign beat_last = beat_q == DW'(WR_DAT_CYC_NUM - 1);
    // rem_q counts chunks still to be issued, including the current one
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        chunk_d = chunk_q;
        rem_d   = rem_q;
        valid_d = accept ? 1'b0 : valid_q;
        sm_d    = sm_q;
        data_d  = data_q;
        cl_d    = cl_q;
        last_d  = last_q;
        done_d  = 1'b0;
        if (abort_i) begin
            state_d = IDLE;
            valid_d = 1'b0;
        end else begin
            if (state_q == IDLE && start_i) begin
                if (chunk_num_i == '0) begin
                    done_d = 1'b1;
                end else begin
                    state_d = RUN;
                    chunk_d = chunk_base_i;
                    beat_d  = '0;
                    rem_d   = chunk_num_i;
                end
            end
            if (issue) begin
                valid_d = 1'b1;
                sm_d    = mem_sparsemap_i;
                data_d  = mem_data_i;
                cl_d    = beat_last;
                last_d  = beat_last && rem_q == (CW+1)'(1);
                beat_d  = beat_q + DW'(1);
                if (beat_last) begin
                    chunk_d = chunk_q + CW'(1);
                    rem_d   = rem_q - (CW+1)'(1);
                    state_d = rem_q == (CW+1)'(1) ? DRAIN : RUN;
                end
            end
            if (state_q == DRAIN && accept) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
        end
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            beat_q  <= '0;
            chunk_q <= '0;
            rem_q   <= '0;
            valid_q <= 1'b0;
            sm_q    <= '0;
            data_q  <= '0;
            cl_q    <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            chunk_q <= chunk_d;
            rem_q   <= rem_d;
            valid_q <= valid_d;
            sm_q    <= sm_d;
            data_q  <= data_d;
            cl_q    <= cl_d;
            last_q  <= last_d;
            done_q  <= done_d;
        end
    end
    assign rd_dat_count_o   = beat_q;
    assign rd_chunk_count_o = chunk_q;
    assign out_valid_o      = valid_q;
    assign out_sparsemap_o  = sm_q;
    assign out_data_o       = data_q;
    assign out_chunk_last_o = cl_q;
    assign out_last_o       = last_q;
    assign busy_o           = state_q != IDLE;
    assign done_o           = done_q;
endmodule

// File: tb/tb_filter_rd_seq.sv
// tb_filter_rd_seq: scoreboard bench for filter_rd_seq with a combinational SRAM model.
module tb_filter_rd_seq;
    typedef struct {
        logic [31:0]  sm;
        logic [255:0] data;
        logic         cl;
        logic         last;
    } beat_t;
    logic clk = 0, rst = 1, start = 0, abort = 0, ready = 1;
    logic [2:0]   base = 0;
    logic [3:0]   num = 0;
    logic [1:0]   rd_dat;
    logic [2:0]   rd_chunk;
    logic [31:0]  mem_sm, out_sm, hold_sm;
    logic [255:0] mem_data, out_data;
    logic         out_valid, out_cl, out_last, busy, done, stall = 0;
    beat_t        q[$];
    int           errors = 0, checks = 0, done_cnt = 0, acc_cnt = 0, d0, first_v, done_at;
    always #5 clk = ~clk;
    filter_rd_seq dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort),
        .chunk_base_i(base), .chunk_num_i(num),
        .rd_dat_count_o(rd_dat), .rd_chunk_count_o(rd_chunk),
        .mem_sparsemap_i(mem_sm), .mem_data_i(mem_data),
        .out_valid_o(out_valid), .out_ready_i(ready),
        .out_sparsemap_o(out_sm), .out_data_o(out_data),
        .out_chunk_last_o(out_cl), .out_last_o(out_last),
        .busy_o(busy), .done_o(done)
    );
    function automatic logic [31:0] smap(input int c, input int b);
        return {8'(c), 8'(b), 8'(c * 4 + b + 17), 8'hA5};
    endfunction
    function automatic logic [255:0] dmap(input int c, input int b);
        logic [255:0] d;
        for (int i = 0; i < 8; i++) d[i*32 +: 32] = smap(c, b) ^ (32'h01020304 * (i + 1));
        return d;
    endfunction
    always_comb begin
        mem_sm   = smap(int'(rd_chunk), int'(rd_dat));
        mem_data = dmap(int'(rd_chunk), int'(rd_dat));
    end
    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic push_exp(input int b, input int n);
        beat_t e;
        for (int k = 0; k < n * 4; k++) begin
            e.sm   = smap((b + k / 4) % 8, k % 4);
            e.data = dmap((b + k / 4) % 8, k % 4);
            e.cl   = (k % 4) == 3;
            e.last = k == n * 4 - 1;
            q.push_back(e);
        end
    endtask
    always @(negedge clk) begin
        if (rst) stall = 0;
        else begin
            if (stall) check("hold", out_sm, hold_sm);
            if (done) done_cnt++;
            if (out_valid && ready) begin
                acc_cnt++;
                if (q.size() == 0) check("extra_beat", 1, 0);
                else begin
                    beat_t e;
                    e = q.pop_front();
                    check("sm", out_sm, e.sm);
                    check("data", out_data, e.data);
                    check("chunk_last", out_cl, e.cl);
                    check("last", out_last, e.last);
                end
            end
            stall   = out_valid && !ready;
            hold_sm = out_sm;
        end
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic go(input int b, input int n);
        base  = 3'(b);
        num   = 4'(n);
        start = 1;
        push_exp(b, n);
        tick();
        start = 0;
    endtask
    task automatic wait_done();
        int n = 0;
        d0 = done_cnt;
        while (!done && n < 200) begin
            tick();
            n++;
        end
        check("done_seen", done, 1);
        tick();
        check("done_pulses", done_cnt - d0, 1);
        check("q_empty", q.size(), 0);
    endtask
    initial begin
        tick();
        tick();
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_addr", {rd_chunk, rd_dat}, 0);
        check("rst_out", {out_sm, out_data, out_cl, out_last}, 0);
        rst = 0;
        tick();
        // stream of two chunks from 0, exact cycle timing
        base = 0; num = 2; start = 1; push_exp(0, 2);
        first_v = -1; done_at = -1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (i == 1) start = 0;
            if (out_valid && first_v < 0) first_v = i;
            if (done) done_at = i;
        end
        check("first_valid_cyc", first_v, 2);
        check("done_cyc", done_at, 10);
        check("q_empty1", q.size(), 0);
        // wrap from chunk 7 to chunk 0
        go(7, 2);
        wait_done();
        // backpressure with alternating ready
        acc_cnt = 0;
        base = 3; num = 1; start = 1; push_exp(3, 1);
        d0 = done_cnt;
        for (int i = 0; i < 40 && !done; i++) begin
            tick();
            start = 0;
            ready = ~ready;
        end
        check("bp_done", done, 1);
        check("bp_accepts", acc_cnt, 4);
        ready = 1;
        tick();
        check("bp_q_empty", q.size(), 0);
        // abort while third beat is on the output
        d0 = done_cnt;
        go(2, 3);
        tick(); tick(); tick();
        check("abort_pre_valid", out_valid, 1);
        abort = 1;
        tick();
        abort = 0;
        check("abort_busy", busy, 0);
        check("abort_valid", out_valid, 0);
        q.delete();
        for (int i = 0; i < 10; i++) tick();
        check("abort_no_done", done_cnt - d0, 0);
        go(4, 1);
        wait_done();
        // zero-length stream
        d0 = done_cnt;
        base = 5; num = 0; start = 1;
        tick();
        start = 0;
        check("zero_done", done, 1);
        check("zero_valid", out_valid, 0);
        for (int i = 0; i < 4; i++) tick();
        check("zero_pulses", done_cnt - d0, 1);
        // start while busy is ignored
        go(0, 1);
        tick();
        base = 5; num = 2; start = 1;
        tick();
        start = 0;
        wait_done();
        // reset mid-stream under backpressure
        ready = 0;
        d0 = done_cnt;
        go(1, 2);
        for (int i = 0; i < 5; i++) tick();
        check("pre_rst_valid", out_valid, 1);
        rst = 1;
        tick();
        check("mrst_valid", out_valid, 0);
        check("mrst_busy", busy, 0);
        check("mrst_addr", {rd_chunk, rd_dat}, 0);
        check("mrst_out", {out_sm, out_data, out_cl, out_last}, 0);
        check("mrst_done", done, 0);
        rst = 0;
        q.delete();
        ready = 1;
        for (int i = 0; i < 5; i++) tick();
        check("mrst_no_done", done_cnt - d0, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
